dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//   Two-port round-robin arbiter and sequencer for the byte-addressed data memory.
//   Takes load/store requests from two requesters, r0 (core LSU) and r1 (debug/DMA).
//   Checks each request for alignment and range, then drives the memory op code
//   for exactly one cycle. Registers the load result and returns it with a status flag.
// PARAMETERS
//   ADDR_BITS  8   byte address width, shared with the memory Address port
//   MEM_BYTES  12  number of implemented memory bytes; valid addresses are 0..MEM_BYTES-1
// PORTS
//   clk            in   1          single clock, rising edge
//   rst            in   1          asynchronous, active-low reset
//   rN_req         in   1          N=0,1: request valid; held until rN_gnt
//   rN_op          in   4          N=0,1: op 1=SW 2=SH 3=SB 4=LW 5=LH 6=LB 7=LHU 8=LBU
//   rN_addr        in   ADDR_BITS  N=0,1: byte address
//   rN_wdata       in   32         N=0,1: store data, right-aligned for SH/SB
//   rN_gnt         out  1          N=0,1: one-cycle pulse; request accepted
//   rN_rvalid      out  1          N=0,1: one-cycle pulse; response valid
//   rN_rdata       out  32         N=0,1: load result; 0 for stores and errors
//   rN_err         out  1          N=0,1: qualified by rN_rvalid; request rejected
//   mem_addr       out  ADDR_BITS  memory Address
//   mem_wdata      out  32         memory Data_in
//   mem_we         out  4          memory op code; 4'b0000 = no access
//   mem_rdata      in   32         memory Data_out, combinational
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, rr_ptr=0.
//     All gnt/rvalid/err outputs 0; all rdata outputs 0.
//     mem_we=0000, mem_addr=0, mem_wdata=0.
//   FSM IDLE -> ISSUE -> RESP -> IDLE; no other transitions.
//   IDLE:
//     - No rN_req set: stay in IDLE.
//     - Else select the owner. With both requesting, owner=rr_ptr; otherwise owner=the
//       single requester.
//     - At the edge: latch owner, op, addr and wdata; compute bad; go to ISSUE.
//   bad is set when any of these holds:
//     - op is 0 or greater than 8;
//     - op is SW/LW and addr[1:0]!=0;
//     - op is SH/LH/LHU and addr[0]!=0;
//     - addr+size-1 > MEM_BYTES-1. size is 4/2/1. Compute this sum ADDR_BITS+1 wide
//       so it cannot wrap.
//   ISSUE (exactly 1 cycle):
//     - owner's gnt=1 this cycle only.
//     - mem_addr and mem_wdata carry the latched values.
//     - mem_we = bad ? 0000 : latched op.
//     - At the edge: rdata_q = (load && !bad) ? mem_rdata : 0; go to RESP.
//   RESP (exactly 1 cycle):
//     - owner's rvalid=1 with rdata=rdata_q and err=bad.
//     - At the edge: rr_ptr = ~owner; go to IDLE.
//   Outputs outside these windows:
//     - mem_we=0000 in IDLE and RESP.
//     - mem_addr/mem_wdata hold their last values.
//     - The non-owner's gnt/rvalid/err and both ports' rdata are 0 outside RESP.
//   Timing: request sampled at edge k gives gnt in cycle k+1 and rvalid in cycle k+2.
//     Peak throughput is one access per 3 cycles.
//   Requesters must hold req/op/addr/wdata stable until their gnt. The controller
//     ignores inputs in ISSUE and RESP.
//   rr_ptr changes only on a completed RESP. Errors count as served.
//   The load sign/zero extension is done by the memory; the controller passes data through.
//   Reset mid-ISSUE: mem_we drops to 0000 asynchronously. A partially sequenced store
//     is abandoned, no rvalid is issued, and no retry is attempted.
// TESTING
//   T1 hold rst=0 with r0_req=1 -> all outputs 0, mem_we=0000, no gnt, for 5 cycles.
//   T2 r0 SW addr 4 wdata 32'hDEADBEEF, then LW addr 4:
//      -> gnt at k+1 with mem_we=0001 then 0100; LW gives rvalid at k+2 with rdata 32'hDEADBEEF, err=0.
//   T3 after T2: LB 4 -> FFFFFFDE; LBU 4 -> 000000DE; LH 6 -> FFFFBEEF; LHU 6 -> 0000BEEF.
//   T4 r0 and r1 both held with LW 0 from reset:
//      -> grants r0,r1,r0,r1; each rvalid goes only to its owner.
//   T5 LW addr 2 -> err=1, rdata=0, mem_we=0000 throughout. SW addr 10 -> err (bytes 10..13 > 11).
//      op 4'hF -> err. SB addr 11 -> ok.
//   T6 rst=0 during ISSUE of SW addr 0:
//      -> mem_we=0000 immediately, no rvalid. After release, r1 LW is granted, with rr_ptr at 0.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl
//
// Purpose:
//   Two-port round-robin arbiter and sequencer for the byte-addressed data
//   memory. Requester r0 is the core LSU, r1 is the debug/DMA port. Each
//   accepted request is checked for a legal op code, natural alignment and
//   address range. The memory op code is then driven for exactly one cycle,
//   and the load result is registered and returned with an error flag.
//
//   Sequence per access: IDLE -> ISSUE -> RESP -> IDLE. A request sampled at
//   edge k produces gnt in cycle k+1 and rvalid in cycle k+2.
//
// Ports:
//   clk        in   1          single clock, rising edge
//   rst        in   1          asynchronous, active-low reset
//   rN_req     in   1          request valid, held until rN_gnt
//   rN_op      in   4          1=SW 2=SH 3=SB 4=LW 5=LH 6=LB 7=LHU 8=LBU
//   rN_addr    in   ADDR_BITS  byte address
//   rN_wdata   in   32         store data, right-aligned for SH/SB
//   rN_gnt     out  1          one-cycle pulse, request accepted
//   rN_rvalid  out  1          one-cycle pulse, response valid
//   rN_rdata   out  32         load result, 0 for stores and errors
//   rN_err     out  1          request rejected (qualified by rN_rvalid)
//   mem_addr   out  ADDR_BITS  memory address
//   mem_wdata  out  32         memory write data
//   mem_we     out  4          memory op code, 4'b0000 = no access
//   mem_rdata  in   32         memory read data (combinational)
// ---------------------------------------------------------------------------
module dmem_access_ctrl #(
    parameter int ADDR_BITS = 8,
    parameter int MEM_BYTES = 12
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 r0_req,
    input  logic [3:0]           r0_op,
    input  logic [ADDR_BITS-1:0] r0_addr,
    input  logic [31:0]          r0_wdata,
    output logic                 r0_gnt,
    output logic                 r0_rvalid,
    output logic [31:0]          r0_rdata,
    output logic                 r0_err,

    input  logic                 r1_req,
    input  logic [3:0]           r1_op,
    input  logic [ADDR_BITS-1:0] r1_addr,
    input  logic [31:0]          r1_wdata,
    output logic                 r1_gnt,
    output logic                 r1_rvalid,
    output logic [31:0]          r1_rdata,
    output logic                 r1_err,

    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_we,
    input  logic [31:0]          mem_rdata
);

    // Highest implemented byte address, one bit wider than the address so
    // the end-of-access comparison below can never wrap.
    localparam logic [ADDR_BITS:0] LAST_ADDR = (ADDR_BITS+1)'(MEM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Latched request and response registers
    logic                 owner_q;
    logic [3:0]           op_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [31:0]          wdata_q;
    logic                 bad_q;
    logic [31:0]          rdata_q;
    logic                 rr_ptr;

    // Owner selection and request decode for the current IDLE cycle
    logic                 any_req;
    logic                 sel_owner;
    logic [3:0]           sel_op;
    logic [ADDR_BITS-1:0] sel_addr;
    logic [31:0]          sel_wdata;
    logic                 sel_bad;

    logic [ADDR_BITS:0]   size_m1;
    logic [ADDR_BITS:0]   last_byte;
    logic                 op_bad;
    logic                 misaligned;
    logic                 out_of_range;
    logic                 op_is_load;

    assign any_req = r0_req | r1_req;

    // With both requesting the round-robin pointer decides; otherwise the
    // single requester wins (r1_req alone selects 1, r0_req alone selects 0).
    assign sel_owner = (r0_req && r1_req) ? rr_ptr : r1_req;
    assign sel_op    = sel_owner ? r1_op    : r0_op;
    assign sel_addr  = sel_owner ? r1_addr  : r0_addr;
    assign sel_wdata = sel_owner ? r1_wdata : r0_wdata;

    // Legality check: op code, natural alignment and range. The last byte
    // touched is computed one bit wider than the address so that e.g. a word
    // access at 8'hFE is seen as out of range instead of wrapping to 1.
    always_comb begin
        size_m1    = '0;
        op_bad     = 1'b0;
        misaligned = 1'b0;
        unique case (sel_op)
            4'd1, 4'd4: begin
                size_m1    = (ADDR_BITS+1)'(3);
                misaligned = (sel_addr[1:0] != 2'b00);
            end
            4'd2, 4'd5, 4'd7: begin
                size_m1    = (ADDR_BITS+1)'(1);
                misaligned = sel_addr[0];
            end
            4'd3, 4'd6, 4'd8: begin
                size_m1    = '0;
            end
            default: begin
                op_bad     = 1'b1;
            end
        endcase
        last_byte    = {1'b0, sel_addr} + size_m1;
        out_of_range = (last_byte > LAST_ADDR);
        sel_bad      = op_bad | misaligned | out_of_range;
    end

    // Only legal loads capture memory data; stores and rejected requests
    // return zero.
    assign op_is_load = (op_q >= 4'd4) && (op_q <= 4'd8);

    // State register. An asynchronous reset returns to IDLE immediately,
    // which also drops mem_we mid-ISSUE and abandons the access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode. Grant, response and memory strobe are
    // all pure functions of the state and the latched owner, so every pulse
    // is exactly one cycle wide.
    always_comb begin
        state_next = state;
        r0_gnt     = 1'b0;
        r1_gnt     = 1'b0;
        r0_rvalid  = 1'b0;
        r1_rvalid  = 1'b0;
        r0_err     = 1'b0;
        r1_err     = 1'b0;
        r0_rdata   = '0;
        r1_rdata   = '0;
        mem_we     = 4'b0000;

        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                r0_gnt     = ~owner_q;
                r1_gnt     = owner_q;
                mem_we     = bad_q ? 4'b0000 : op_q;
                state_next = RESP;
            end
            RESP: begin
                r0_rvalid  = ~owner_q;
                r1_rvalid  = owner_q;
                r0_err     = ~owner_q & bad_q;
                r1_err     = owner_q & bad_q;
                r0_rdata   = owner_q ? 32'd0 : rdata_q;
                r1_rdata   = owner_q ? rdata_q : 32'd0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture. The address and write data registers feed the memory
    // directly and are only reloaded on acceptance, so the memory bus holds
    // its last values between accesses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= 1'b0;
            op_q    <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            bad_q   <= 1'b0;
        end else if (state == IDLE && any_req) begin
            owner_q <= sel_owner;
            op_q    <= sel_op;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            bad_q   <= sel_bad;
        end
    end

    // Load result capture at the end of ISSUE, while the memory is still
    // presenting data for the latched address and op code.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (state == ISSUE) begin
            rdata_q <= (op_is_load && !bad_q) ? mem_rdata : 32'd0;
        end
    end

    // Round-robin pointer favours the port that was not just served. It only
    // moves on a completed response, so an access cut short by reset leaves
    // the priority untouched. Rejected requests count as served.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= 1'b0;
        end else if (state == RESP) begin
            rr_ptr <= ~owner_q;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_access_ctrl
//
// Directed bench for dmem_access_ctrl. A small big-endian 12-byte memory
// model performs sign/zero extension for loads and commits stores on the
// rising edge while mem_we carries a store code.
// ---------------------------------------------------------------------------
module tb_dmem_access_ctrl;

    localparam int ADDR_BITS = 8;
    localparam int MEM_BYTES = 12;

    logic                 clk;
    logic                 rst;
    logic                 r0_req;
    logic [3:0]           r0_op;
    logic [ADDR_BITS-1:0] r0_addr;
    logic [31:0]          r0_wdata;
    logic                 r0_gnt;
    logic                 r0_rvalid;
    logic [31:0]          r0_rdata;
    logic                 r0_err;
    logic                 r1_req;
    logic [3:0]           r1_op;
    logic [ADDR_BITS-1:0] r1_addr;
    logic [31:0]          r1_wdata;
    logic                 r1_gnt;
    logic                 r1_rvalid;
    logic [31:0]          r1_rdata;
    logic                 r1_err;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [31:0]          mem_wdata;
    logic [3:0]           mem_we;
    logic [31:0]          mem_rdata;

    int checks = 0;
    int errors = 0;

    dmem_access_ctrl #(
        .ADDR_BITS (ADDR_BITS),
        .MEM_BYTES (MEM_BYTES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .r0_req    (r0_req),
        .r0_op     (r0_op),
        .r0_addr   (r0_addr),
        .r0_wdata  (r0_wdata),
        .r0_gnt    (r0_gnt),
        .r0_rvalid (r0_rvalid),
        .r0_rdata  (r0_rdata),
        .r0_err    (r0_err),
        .r1_req    (r1_req),
        .r1_op     (r1_op),
        .r1_addr   (r1_addr),
        .r1_wdata  (r1_wdata),
        .r1_gnt    (r1_gnt),
        .r1_rvalid (r1_rvalid),
        .r1_rdata  (r1_rdata),
        .r1_err    (r1_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: bytes start as 8'h10+i, stored big-endian.
    logic [7:0] mem [0:MEM_BYTES-1];
    bit         mem_ready = 1'b0;

    function automatic logic [7:0] rd_byte(input logic [8:0] a);
        return (a < 9'(MEM_BYTES)) ? mem[a[3:0]] : 8'h00;
    endfunction

    always_comb begin
        logic [8:0]  a;
        logic [15:0] half;
        logic [7:0]  b;
        a    = {1'b0, mem_addr};
        half = {rd_byte(a), rd_byte(a + 9'd1)};
        b    = rd_byte(a);
        mem_rdata = 32'd0;
        case (mem_we)
            4'd4:    mem_rdata = {rd_byte(a), rd_byte(a + 9'd1), rd_byte(a + 9'd2), rd_byte(a + 9'd3)};
            4'd5:    mem_rdata = {{16{half[15]}}, half};
            4'd6:    mem_rdata = {{24{b[7]}}, b};
            4'd7:    mem_rdata = {16'd0, half};
            4'd8:    mem_rdata = {24'd0, b};
            default: mem_rdata = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h10 + 8'(i);
            mem_ready = 1'b1;
        end else begin
            case (mem_we)
                4'd1: for (int i = 0; i < 4; i++)
                          if (int'(mem_addr) + i < MEM_BYTES)
                              mem[int'(mem_addr) + i] = mem_wdata[31 - 8*i -: 8];
                4'd2: for (int i = 0; i < 2; i++)
                          if (int'(mem_addr) + i < MEM_BYTES)
                              mem[int'(mem_addr) + i] = mem_wdata[15 - 8*i -: 8];
                4'd3: if (int'(mem_addr) < MEM_BYTES)
                          mem[int'(mem_addr)] = mem_wdata[7:0];
                default: ;
            endcase
        end
    end

    // Single comparison point: counts and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete access on a single port: request in the IDLE cycle, then
    // check the grant cycle and the response cycle at fixed offsets.
    task automatic applyStimulus(input string tag, input bit port, input logic [3:0] op,
                                 input logic [7:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] exp_we, input logic [31:0] exp_rdata,
                                 input bit exp_err);
        @(negedge clk);
        if (port) begin
            r1_req = 1'b1; r1_op = op; r1_addr = addr; r1_wdata = wdata;
        end else begin
            r0_req = 1'b1; r0_op = op; r0_addr = addr; r0_wdata = wdata;
        end
        @(negedge clk);
        checkOutput({tag, "_gnt"},   32'(port ? r1_gnt : r0_gnt), 32'd1);
        checkOutput({tag, "_ngnt"},  32'(port ? r0_gnt : r1_gnt), 32'd0);
        checkOutput({tag, "_we"},    32'(mem_we), 32'(exp_we));
        checkOutput({tag, "_addr"},  32'(mem_addr), 32'(addr));
        checkOutput({tag, "_earlyrv"}, 32'(r0_rvalid | r1_rvalid), 32'd0);
        r0_req = 1'b0;
        r1_req = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_rvalid"}, 32'(port ? r1_rvalid : r0_rvalid), 32'd1);
        checkOutput({tag, "_nrvalid"}, 32'(port ? r0_rvalid : r1_rvalid), 32'd0);
        checkOutput({tag, "_rdata"}, port ? r1_rdata : r0_rdata, exp_rdata);
        checkOutput({tag, "_err"},   32'(port ? r1_err : r0_err), 32'(exp_err));
        checkOutput({tag, "_respwe"}, 32'(mem_we), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b0;
        r0_req = 1'b1; r0_op = 4'd1; r0_addr = 8'd4; r0_wdata = 32'hDEADBEEF;
        r1_req = 1'b0; r1_op = 4'd0; r1_addr = 8'd0; r1_wdata = 32'd0;

        // T1: reset held with a pending request
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("t1_gnt",    32'({r1_gnt, r0_gnt}), 32'd0);
            checkOutput("t1_rvalid", 32'({r1_rvalid, r0_rvalid, r1_err, r0_err}), 32'd0);
            checkOutput("t1_rdata",  r0_rdata | r1_rdata, 32'd0);
            checkOutput("t1_we",     32'(mem_we), 32'd0);
            checkOutput("t1_maddr",  32'(mem_addr), 32'd0);
            checkOutput("t1_mwdata", mem_wdata, 32'd0);
        end
        rst    = 1'b1;
        r0_req = 1'b0;

        // T2: store then load back
        applyStimulus("t2_sw", 1'b0, 4'd1, 8'd4, 32'hDEADBEEF, 4'd1, 32'd0,        1'b0);
        applyStimulus("t2_lw", 1'b0, 4'd4, 8'd4, 32'd0,        4'd4, 32'hDEADBEEF, 1'b0);

        // T3: extension variants done by the memory
        applyStimulus("t3_lb",  1'b0, 4'd6, 8'd4, 32'd0, 4'd6, 32'hFFFFFFDE, 1'b0);
        applyStimulus("t3_lbu", 1'b0, 4'd8, 8'd4, 32'd0, 4'd8, 32'h000000DE, 1'b0);
        applyStimulus("t3_lh",  1'b0, 4'd5, 8'd6, 32'd0, 4'd5, 32'hFFFFBEEF, 1'b0);
        applyStimulus("t3_lhu", 1'b0, 4'd7, 8'd6, 32'd0, 4'd7, 32'h0000BEEF, 1'b0);

        // T4: both ports held from reset, grants alternate r0,r1,r0,r1
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        r0_req = 1'b1; r0_op = 4'd4; r0_addr = 8'd0;
        r1_req = 1'b1; r1_op = 4'd4; r1_addr = 8'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("t4_gnt", 32'({r1_gnt, r0_gnt}), (i % 2 == 0) ? 32'd1 : 32'd2);
            checkOutput("t4_we",  32'(mem_we), 32'd4);
            @(negedge clk);
            checkOutput("t4_rvalid", 32'({r1_rvalid, r0_rvalid}), (i % 2 == 0) ? 32'd1 : 32'd2);
            checkOutput("t4_rdata0", r0_rdata, (i % 2 == 0) ? 32'h10111213 : 32'd0);
            checkOutput("t4_rdata1", r1_rdata, (i % 2 == 0) ? 32'd0 : 32'h10111213);
            @(negedge clk);
            if (i == 3) begin
                r0_req = 1'b0;
                r1_req = 1'b0;
            end
        end

        // T5: rejection and range boundaries
        applyStimulus("t5_lw2",  1'b0, 4'd4, 8'd2,  32'd0,        4'd0, 32'd0,        1'b1);
        applyStimulus("t5_sw10", 1'b1, 4'd1, 8'd10, 32'h12345678, 4'd0, 32'd0,        1'b1);
        applyStimulus("t5_opf",  1'b0, 4'hF, 8'd0,  32'd0,        4'd0, 32'd0,        1'b1);
        applyStimulus("t5_lh11", 1'b1, 4'd5, 8'd11, 32'd0,        4'd0, 32'd0,        1'b1);
        applyStimulus("t5_sb11", 1'b1, 4'd3, 8'd11, 32'h000000A5, 4'd3, 32'd0,        1'b0);
        applyStimulus("t5_lbu",  1'b0, 4'd8, 8'd11, 32'd0,        4'd8, 32'h000000A5, 1'b0);
        applyStimulus("t5_lw8",  1'b1, 4'd4, 8'd8,  32'd0,        4'd4, 32'h18191AA5, 1'b0);

        // T6: reset during ISSUE of a store
        @(negedge clk);
        r0_req = 1'b1; r0_op = 4'd1; r0_addr = 8'd0; r0_wdata = 32'h11223344;
        @(negedge clk);
        checkOutput("t6_we_issue", 32'(mem_we), 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("t6_we_async", 32'(mem_we), 32'd0);
        checkOutput("t6_gnt_async", 32'({r1_gnt, r0_gnt}), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("t6_norvalid", 32'({r1_rvalid, r0_rvalid}), 32'd0);
        end
        rst    = 1'b1;
        r0_req = 1'b0;
        applyStimulus("t6_r1lw", 1'b1, 4'd4, 8'd0, 32'd0, 4'd4, 32'h10111213, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
